instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Pipeline IF stage for the MIPS datapath: owns the PC register, next-PC selection, the instruction memory and the IF/ID pipeline register. Consumes `write_pc`/`stall_ID` from the hazard detection unit, `flush_IF`/`pc_src` from the branch/jump logic in ID, and `enable` plus the program-load port from the debug unit. Produces the IF/ID instruction and PC+4 consumed by ID, and a sticky `halt` flag for the debug unit.

## Interface
- `NBITS`, 32: instruction, PC and address width.
- `IMEM_DEPTH`, 256: instruction memory depth in words (power of two).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: debug run/step enable; 0 freezes all state except memory writes.
- `write_pc` in 1: hazard unit PC write enable.
- `stall_ID` in 1: hazard unit IF/ID hold.
- `flush_IF` in 1: squash instruction currently in IF (taken branch/jump in ID).
- `pc_src` in 2: next-PC select: 00 PC+4, 01 branch, 10 jump, 11 jump-register.
- `branch_addr`, `jump_addr`, `jr_addr` in NBITS each: byte targets from ID.
- `imem_we` in 1: loader write strobe.
- `imem_waddr` in NBITS: loader byte address.
- `imem_wdata` in NBITS: loader word.
- `IF_ID_instr` out NBITS: registered instruction.
- `IF_ID_pc4` out NBITS: registered PC+4 of that instruction.
- `pc_out` out NBITS: current PC (debug readout).
- `halt` out 1: sticky, HALT reached IF/ID.

## Operation
- Memory read: asynchronous, word index `pc[log2(IMEM_DEPTH)+1:2]`; upper bits ignored (fetch wraps modulo 4*IMEM_DEPTH). PC bits [1:0] ignored.
- Memory write: synchronous on `imem_we`, index from `imem_waddr` likewise; independent of `enable`, `halt`, hazards. Same-cycle read of the written word returns old data.
- Next PC: `pc_src` mux; PC+4 is `pc_out + 4`, modulo 2^NBITS.
- Per-edge priority (enable=1): 
  1. `stall_ID`=1: PC and IF/ID hold; `flush_IF` ignored (branch in ID is itself stalled).
  2. `flush_IF`=1: PC loads selected target; IF/ID loads NOP (instr 0, pc4 0); halt not set by squashed word.
  3. `halt`=1: PC holds; IF/ID loads NOP each edge (pipeline drains).
  4. fetched word opcode [31:26] = HALT: IF/ID loads it, `halt` sets, PC holds.
  5. otherwise: PC loads mux output if `write_pc`=1 else holds; IF/ID loads fetched word and PC+4.
- `write_pc`=0 with `stall_ID`=0 holds PC but still loads IF/ID.
- `enable`=0: PC, IF/ID, `halt` hold regardless of other inputs.
- `halt` clears only on reset.

## Timing
- Reset (async, immediate): PC=0, `IF_ID_instr`=0, `IF_ID_pc4`=0, `halt`=0. Memory contents not reset.
- Reset release mid-load or mid-run: first edge after deassertion fetches address 0.
- Fetch-to-IF/ID latency: 1 cycle. Target taken the edge `flush_IF` is sampled; target instruction in IF/ID one cycle later (one bubble).
- `halt` asserts on the same edge HALT enters IF/ID.
- `pc_out` combinational from PC register; all other outputs registered.

## Structure
- Shared package: NOP word (0), HALT opcode (6'b111111), `pc_src` encodings, default NBITS.
- Sub-module `instruction_memory`: async-read, sync-write word RAM parameterised by NBITS and IMEM_DEPTH; PC mux, PC register, halt flag and IF/ID register live in the top.

## Test plan
- Load words 0x20010005, 0x20020007, HALT at 0,4,8; enable=1 -> IF_ID_instr sequence 0x20010005, 0x20020007, 0xFC000000, then 0; halt=1 from third edge; pc_out stays 8.
- Running, assert write_pc=0, stall_ID=1 one cycle at pc=4 -> pc_out and IF_ID_instr unchanged that edge, resume next.
- flush_IF=1, pc_src=01, branch_addr=0x40 -> next edge pc_out=0x40, IF_ID_instr=0, IF_ID_pc4=0; HALT at squashed address does not set halt.
- flush_IF=1 with stall_ID=1 -> PC and IF/ID hold; flush honoured next cycle when stall drops.
- enable=0 for 5 cycles with loader writes -> pc_out/IF/ID frozen, written words fetched correctly after enable=1; pc_out=0x3FC with PC+4 wraps fetch to word 0 (IMEM_DEPTH=256).
- Assert reset mid-run between edges -> outputs 0 immediately; halt cleared; fetch restarts at 0.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared constants and encodings for the MIPS instruction fetch stage.
// Imported by the IF top and its instruction memory.
package instruction_fetch_pkg;

  localparam int NBITS_DEFAULT      = 32;
  localparam int IMEM_DEPTH_DEFAULT = 256;

  localparam logic [31:0] NOP_WORD    = 32'h0000_0000;
  localparam logic [5:0]  HALT_OPCODE = 6'b111111;

  typedef enum logic [1:0] {
    PC_SRC_SEQ    = 2'b00,
    PC_SRC_BRANCH = 2'b01,
    PC_SRC_JUMP   = 2'b10,
    PC_SRC_JR     = 2'b11
  } pc_src_e;

  // Opcode field sits in the top six bits of every instruction word.
  function automatic logic is_halt_opcode(input logic [5:0] opcode);
    return opcode == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction RAM: asynchronous read, synchronous write.
// Byte addresses are reduced to a word index; upper bits alias (wrap).
module instruction_memory
  import instruction_fetch_pkg::*;
#(
  parameter int NBITS      = NBITS_DEFAULT,
  parameter int IMEM_DEPTH = IMEM_DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic [NBITS-1:0] raddr,
  output logic [NBITS-1:0] rdata,
  input  logic             we,
  input  logic [NBITS-1:0] waddr,
  input  logic [NBITS-1:0] wdata
);

  localparam int AW = $clog2(IMEM_DEPTH);

  logic [NBITS-1:0] mem [IMEM_DEPTH];
  logic [AW-1:0]    ridx;
  logic [AW-1:0]    widx;

  assign ridx  = raddr[AW+1:2];
  assign widx  = waddr[AW+1:2];
  assign rdata = mem[ridx];

  // Contents are deliberately not reset; the loader owns them.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{raddr[NBITS-1:AW+2], raddr[1:0],
                              waddr[NBITS-1:AW+2], waddr[1:0]};

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC register, next-PC mux, instruction memory and IF/ID register.
// Produces a sticky halt once a HALT opcode lands in IF/ID.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int NBITS      = NBITS_DEFAULT,
  parameter int IMEM_DEPTH = IMEM_DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             write_pc,
  input  logic             stall_ID,
  input  logic             flush_IF,
  input  logic [1:0]       pc_src,
  input  logic [NBITS-1:0] branch_addr,
  input  logic [NBITS-1:0] jump_addr,
  input  logic [NBITS-1:0] jr_addr,
  input  logic             imem_we,
  input  logic [NBITS-1:0] imem_waddr,
  input  logic [NBITS-1:0] imem_wdata,
  output logic [NBITS-1:0] IF_ID_instr,
  output logic [NBITS-1:0] IF_ID_pc4,
  output logic [NBITS-1:0] pc_out,
  output logic             halt
);

  localparam logic [NBITS-1:0] NOP = NBITS'(NOP_WORD);

  logic [NBITS-1:0] pc_q;
  logic [NBITS-1:0] pc_d;
  logic [NBITS-1:0] instr_q;
  logic [NBITS-1:0] instr_d;
  logic [NBITS-1:0] pc4_q;
  logic [NBITS-1:0] pc4_d;
  logic             halt_q;
  logic             halt_d;

  logic [NBITS-1:0] pc_plus4;
  logic [NBITS-1:0] pc_target;
  logic [NBITS-1:0] fetched;
  logic             fetched_halt;

  instruction_memory #(
    .NBITS      (NBITS),
    .IMEM_DEPTH (IMEM_DEPTH)
  ) u_imem (
    .clk   (clk),
    .raddr (pc_q),
    .rdata (fetched),
    .we    (imem_we),
    .waddr (imem_waddr),
    .wdata (imem_wdata)
  );

  assign pc_plus4     = pc_q + NBITS'(4);
  assign fetched_halt = is_halt_opcode(fetched[NBITS-1 -: 6]);

  always_comb begin
    pc_target = pc_plus4;
    case (pc_src_e'(pc_src))
      PC_SRC_SEQ:    pc_target = pc_plus4;
      PC_SRC_BRANCH: pc_target = branch_addr;
      PC_SRC_JUMP:   pc_target = jump_addr;
      PC_SRC_JR:     pc_target = jr_addr;
      default:       pc_target = pc_plus4;
    endcase
  end

  // Priority: stall > flush > already halted > fetched HALT > normal fetch.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    halt_d  = halt_q;
    if (enable && !stall_ID) begin
      if (flush_IF) begin
        pc_d    = pc_target;
        instr_d = NOP;
        pc4_d   = NOP;
      end else if (halt_q) begin
        instr_d = NOP;
        pc4_d   = NOP;
      end else if (fetched_halt) begin
        instr_d = fetched;
        pc4_d   = pc_plus4;
        halt_d  = 1'b1;
      end else begin
        if (write_pc) begin
          pc_d = pc_target;
        end
        instr_d = fetched;
        pc4_d   = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= '0;
      instr_q <= NOP;
      pc4_q   <= '0;
      halt_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      halt_q  <= halt_d;
    end
  end

  assign pc_out      = pc_q;
  assign IF_ID_instr = instr_q;
  assign IF_ID_pc4   = pc4_q;
  assign halt        = halt_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch.
// Each scenario task drives stimulus and checks hand-computed values inline.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        write_pc;
  logic        stall_ID;
  logic        flush_IF;
  logic [1:0]  pc_src;
  logic [31:0] branch_addr;
  logic [31:0] jump_addr;
  logic [31:0] jr_addr;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic [31:0] IF_ID_instr;
  logic [31:0] IF_ID_pc4;
  logic [31:0] pc_out;
  logic        halt;

  int errors = 0;
  int checks = 0;

  instruction_fetch #(.NBITS(32), .IMEM_DEPTH(256)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .write_pc    (write_pc),
    .stall_ID    (stall_ID),
    .flush_IF    (flush_IF),
    .pc_src      (pc_src),
    .branch_addr (branch_addr),
    .jump_addr   (jump_addr),
    .jr_addr     (jr_addr),
    .imem_we     (imem_we),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata),
    .IF_ID_instr (IF_ID_instr),
    .IF_ID_pc4   (IF_ID_pc4),
    .pc_out      (pc_out),
    .halt        (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
    imem_we    = 1'b1;
    imem_waddr = addr;
    imem_wdata = data;
    tick();
    imem_we = 1'b0;
  endtask

  task automatic expect_state(input string name, input logic [31:0] e_pc,
                              input logic [31:0] e_instr, input logic [31:0] e_pc4,
                              input logic e_halt);
    checks++;
    if (pc_out !== e_pc) begin
      errors++;
      $display("FAIL %s pc_out: got %h want %h", name, pc_out, e_pc);
    end
    checks++;
    if (IF_ID_instr !== e_instr) begin
      errors++;
      $display("FAIL %s IF_ID_instr: got %h want %h", name, IF_ID_instr, e_instr);
    end
    checks++;
    if (IF_ID_pc4 !== e_pc4) begin
      errors++;
      $display("FAIL %s IF_ID_pc4: got %h want %h", name, IF_ID_pc4, e_pc4);
    end
    checks++;
    if (halt !== e_halt) begin
      errors++;
      $display("FAIL %s halt: got %b want %b", name, halt, e_halt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    expect_state("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    load_word(32'h000, 32'h2001_0005);
    load_word(32'h004, 32'h2002_0007);
    load_word(32'h008, 32'hFC00_0000);
    load_word(32'h040, 32'h2003_0001);
    load_word(32'h044, 32'h2004_0002);
    load_word(32'h080, 32'h2005_0003);
    expect_state("reset_hold", 32'h0, 32'h0, 32'h0, 1'b0);
    #2;
    reset = 1'b0;
  endtask

  task automatic test_basic_halt();
    enable = 1'b1;
    tick();
    expect_state("basic_e1", 32'h4, 32'h2001_0005, 32'h4, 1'b0);
    tick();
    expect_state("basic_e2", 32'h8, 32'h2002_0007, 32'h8, 1'b0);
    tick();
    expect_state("basic_e3", 32'h8, 32'hFC00_0000, 32'hC, 1'b1);
    tick();
    expect_state("basic_e4", 32'h8, 32'h0, 32'h0, 1'b1);
  endtask

  task automatic test_stall();
    #2;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    write_pc = 1'b0;
    tick();
    expect_state("wpc0_hold", 32'h0, 32'h2001_0005, 32'h4, 1'b0);
    write_pc = 1'b1;
    tick();
    expect_state("wpc1_run", 32'h4, 32'h2001_0005, 32'h4, 1'b0);
    write_pc = 1'b0;
    stall_ID = 1'b1;
    tick();
    expect_state("stall", 32'h4, 32'h2001_0005, 32'h4, 1'b0);
    write_pc = 1'b1;
    stall_ID = 1'b0;
    tick();
    expect_state("stall_resume", 32'h8, 32'h2002_0007, 32'h8, 1'b0);
  endtask

  task automatic test_flush();
    flush_IF    = 1'b1;
    pc_src      = 2'b01;
    branch_addr = 32'h40;
    tick();
    expect_state("flush", 32'h40, 32'h0, 32'h0, 1'b0);
    flush_IF = 1'b0;
    pc_src   = 2'b00;
    tick();
    expect_state("flush_target", 32'h44, 32'h2003_0001, 32'h44, 1'b0);
  endtask

  task automatic test_flush_stall();
    flush_IF  = 1'b1;
    stall_ID  = 1'b1;
    pc_src    = 2'b10;
    jump_addr = 32'h80;
    tick();
    expect_state("flush_stall", 32'h44, 32'h2003_0001, 32'h44, 1'b0);
    stall_ID = 1'b0;
    tick();
    expect_state("flush_after_stall", 32'h80, 32'h0, 32'h0, 1'b0);
    flush_IF = 1'b0;
    pc_src   = 2'b00;
    tick();
    expect_state("jump_target", 32'h84, 32'h2005_0003, 32'h84, 1'b0);
  endtask

  task automatic test_enable_freeze();
    enable      = 1'b0;
    flush_IF    = 1'b1;
    pc_src      = 2'b01;
    branch_addr = 32'h100;
    load_word(32'h084, 32'h2007_0004);
    load_word(32'h3FC, 32'h2006_000A);
    load_word(32'h000, 32'h2008_0008);
    load_word(32'h404, 32'h2009_0009);
    load_word(32'h088, 32'h200A_000A);
    expect_state("freeze", 32'h84, 32'h2005_0003, 32'h84, 1'b0);
    flush_IF = 1'b0;
    pc_src   = 2'b00;
    enable   = 1'b1;
    tick();
    expect_state("unfreeze", 32'h88, 32'h2007_0004, 32'h88, 1'b0);
    flush_IF = 1'b1;
    pc_src   = 2'b11;
    jr_addr  = 32'h3FC;
    tick();
    expect_state("jr_flush", 32'h3FC, 32'h0, 32'h0, 1'b0);
    flush_IF = 1'b0;
    pc_src   = 2'b00;
    tick();
    expect_state("top_word", 32'h400, 32'h2006_000A, 32'h400, 1'b0);
    tick();
    expect_state("wrap_word0", 32'h404, 32'h2008_0008, 32'h404, 1'b0);
  endtask

  task automatic test_reset_midrun();
    tick();
    expect_state("wrap_word1", 32'h408, 32'h2009_0009, 32'h408, 1'b0);
    tick();
    expect_state("wrap_halt", 32'h408, 32'hFC00_0000, 32'h40C, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    expect_state("midrun_reset", 32'h0, 32'h0, 32'h0, 1'b0);
    #1;
    reset = 1'b0;
    tick();
    expect_state("restart", 32'h4, 32'h2008_0008, 32'h4, 1'b0);
  endtask

  initial begin
    reset       = 1'b0;
    enable      = 1'b0;
    write_pc    = 1'b1;
    stall_ID    = 1'b0;
    flush_IF    = 1'b0;
    pc_src      = 2'b00;
    branch_addr = 32'h0;
    jump_addr   = 32'h0;
    jr_addr     = 32'h0;
    imem_we     = 1'b0;
    imem_waddr  = 32'h0;
    imem_wdata  = 32'h0;
    #2;
    test_reset();
    test_basic_halt();
    test_stall();
    test_flush();
    test_flush_stall();
    test_enable_freeze();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
